// File: rtl/spike_pkg.sv
// Shared definitions for the multichannel NEO spike processor.
// Contents:
//   EV_NONE/EV_POS/EV_NEG/EV_SUPP - 2-bit per-lane event codes
//   psi_width()                   - bit width of the signed NEO result
package spike_pkg;

  localparam logic [1:0] EV_NONE = 2'b00;  // no crossing this frame
  localparam logic [1:0] EV_POS  = 2'b01;  // spike, centre sample x1 >= 0
  localparam logic [1:0] EV_NEG  = 2'b10;  // spike, centre sample x1 < 0
  localparam logic [1:0] EV_SUPP = 2'b11;  // crossing swallowed by refractory

  // x1*x1 - x0*x2 of two DATA_WIDTH signed values needs one extra bit over the product width.
  function automatic int unsigned psi_width(input int unsigned data_width);
    return 2 * data_width + 1;
  endfunction

endpackage

// File: rtl/neo_lane.sv
// One NEO detector lane: sample history, fill count, refractory counter, threshold compare and
// the frame-local spike flag / event code.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   i_valid      - a stage-2 sample belongs to this lane
//   i_enable     - lane enable captured with that sample
//   i_clear      - drop frame-local flag/code (frame published or discarded)
//   i_sample     - signed sample x0
//   i_threshold  - unsigned NEO threshold
//   o_spike      - frame-local spike flag
//   o_event      - frame-local event code
module neo_lane
  import spike_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned REFRACTORY = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_valid,
  input  logic                         i_enable,
  input  logic                         i_clear,
  input  logic signed [DATA_WIDTH-1:0] i_sample,
  input  logic [2*DATA_WIDTH-1:0]      i_threshold,
  output logic                         o_spike,
  output logic [1:0]                   o_event
);

  localparam int unsigned PsiW = psi_width(DATA_WIDTH);
  localparam int unsigned RefW = $clog2(REFRACTORY + 1);

  logic signed [DATA_WIDTH-1:0] r_x1, r_x2, w_x1_d, w_x2_d;
  logic [1:0]                   r_fill, w_fill_d;
  logic [RefW-1:0]              r_refr, w_refr_d;
  logic                         r_spike, w_spike_d, w_spike_base;
  logic [1:0]                   r_event, w_event_d, w_event_base;

  logic signed [PsiW-1:0] w_x0e, w_x1e, w_x2e, w_psi;
  logic                   w_cross;

  // Sign-extend before multiplying so the products and difference are exact at PsiW bits.
  assign w_x0e = {{(PsiW - DATA_WIDTH){i_sample[DATA_WIDTH-1]}}, i_sample};
  assign w_x1e = {{(PsiW - DATA_WIDTH){r_x1[DATA_WIDTH-1]}}, r_x1};
  assign w_x2e = {{(PsiW - DATA_WIDTH){r_x2[DATA_WIDTH-1]}}, r_x2};
  assign w_psi = (w_x1e * w_x1e) - (w_x0e * w_x2e);

  // A negative psi clamps to 0, which can never exceed an unsigned threshold.
  assign w_cross = i_enable && (r_fill == 2'd2) && !w_psi[PsiW-1] &&
                   (w_psi[PsiW-2:0] > i_threshold);

  always_comb begin
    // Clear and a same-edge update of this lane merge: the update lands on a fresh frame.
    w_spike_base = i_clear ? 1'b0 : r_spike;
    w_event_base = i_clear ? EV_NONE : r_event;
    w_spike_d    = w_spike_base;
    w_event_d    = w_event_base;
    w_x1_d       = r_x1;
    w_x2_d       = r_x2;
    w_fill_d     = r_fill;
    w_refr_d     = r_refr;
    // A disabled lane consumes its slot but freezes all state.
    if (i_valid && i_enable) begin
      w_x1_d = i_sample;
      w_x2_d = r_x1;
      if (r_fill != 2'd2) w_fill_d = r_fill + 2'd1;
      if (w_cross && (r_refr == '0)) begin
        w_spike_d = 1'b1;
        w_event_d = r_x1[DATA_WIDTH-1] ? EV_NEG : EV_POS;
        w_refr_d  = RefW'(REFRACTORY);
      end else begin
        if (r_refr != '0) w_refr_d = r_refr - RefW'(1);
        if (w_cross && !w_spike_base) w_event_d = EV_SUPP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x1    <= '0;
      r_x2    <= '0;
      r_fill  <= '0;
      r_refr  <= '0;
      r_spike <= 1'b0;
      r_event <= EV_NONE;
    end else begin
      r_x1    <= w_x1_d;
      r_x2    <= w_x2_d;
      r_fill  <= w_fill_d;
      r_refr  <= w_refr_d;
      r_spike <= w_spike_d;
      r_event <= w_event_d;
    end
  end

  assign o_spike = r_spike;
  assign o_event = r_event;

endmodule

// File: rtl/multichannel_spike_processor.sv
// Demultiplexes an interleaved sample stream round-robin over NUM_CHANNELS NEO detector lanes
// and publishes one frame of spike flags and event codes per completed channel sweep.
// Ports:
//   clk, rst_n         - clock, synchronous active-low reset
//   sample_in          - signed sample, accepted when sample_valid_in
//   frame_sync         - with sample_valid_in: route this sample to lane 0, drop partial frame
//   threshold_in/_we   - load a new NEO threshold
//   channel_enable     - per-lane enable, sampled with each sample
//   spike_array        - per-lane spike flags of the last frame
//   event_array        - per-lane 2-bit event codes, lane i at [2i+1:2i]
//   frame_valid        - one-cycle pulse when the arrays update
module multichannel_spike_processor
  import spike_pkg::*;
#(
  parameter int unsigned               NUM_CHANNELS      = 4,
  parameter int unsigned               DATA_WIDTH        = 16,
  parameter logic [2*DATA_WIDTH-1:0]   THRESHOLD_DEFAULT = 10000,
  parameter int unsigned               REFRACTORY        = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic signed [DATA_WIDTH-1:0]  sample_in,
  input  logic                          sample_valid_in,
  input  logic                          frame_sync,
  input  logic [2*DATA_WIDTH-1:0]       threshold_in,
  input  logic                          threshold_we,
  input  logic [NUM_CHANNELS-1:0]       channel_enable,
  output logic [NUM_CHANNELS-1:0]       spike_array,
  output logic [2*NUM_CHANNELS-1:0]     event_array,
  output logic                          frame_valid
);

  localparam int unsigned LaneW    = $clog2(NUM_CHANNELS);
  localparam logic [LaneW-1:0] LastLane = LaneW'(NUM_CHANNELS - 1);

  logic [LaneW-1:0]              r_ptr, w_lane, w_ptr_d;
  logic                          r_s1_valid, r_s1_en, r_s1_sync;
  logic signed [DATA_WIDTH-1:0]  r_s1_sample;
  logic [LaneW-1:0]              r_s1_lane;
  logic [2*DATA_WIDTH-1:0]       r_threshold;
  logic                          r_close;
  logic                          w_clear;
  logic [NUM_CHANNELS-1:0]       w_lane_spike, r_spike_array;
  logic [2*NUM_CHANNELS-1:0]     w_lane_event, r_event_array;
  logic                          r_frame_valid;

  assign w_lane  = frame_sync ? '0 : r_ptr;
  assign w_ptr_d = (w_lane == LastLane) ? '0 : w_lane + LaneW'(1);

  // Lanes drop frame-local state when the previous frame is published, or when a frame_sync
  // sample reaches stage 2 (that sample then lands on the freshly cleared lane 0).
  assign w_clear = r_close || (r_s1_valid && r_s1_sync);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr         <= '0;
      r_s1_valid    <= 1'b0;
      r_s1_en       <= 1'b0;
      r_s1_sync     <= 1'b0;
      r_s1_sample   <= '0;
      r_s1_lane     <= '0;
      r_threshold   <= THRESHOLD_DEFAULT;
      r_close       <= 1'b0;
      r_spike_array <= '0;
      r_event_array <= '0;
      r_frame_valid <= 1'b0;
    end else begin
      r_s1_valid <= sample_valid_in;
      if (sample_valid_in) begin
        r_s1_sample <= sample_in;
        r_s1_lane   <= w_lane;
        r_s1_en     <= channel_enable[w_lane];
        r_s1_sync   <= frame_sync;
        r_ptr       <= w_ptr_d;
      end
      if (threshold_we) r_threshold <= threshold_in;
      // Last lane processed in stage 2 this edge; its results are in the lane registers next.
      r_close       <= r_s1_valid && (r_s1_lane == LastLane);
      r_frame_valid <= r_close;
      if (r_close) begin
        r_spike_array <= w_lane_spike;
        r_event_array <= w_lane_event;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_lane
    neo_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .REFRACTORY (REFRACTORY)
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_valid     (r_s1_valid && (r_s1_lane == LaneW'(gi))),
      .i_enable    (r_s1_en),
      .i_clear     (w_clear),
      .i_sample    (r_s1_sample),
      .i_threshold (r_threshold),
      .o_spike     (w_lane_spike[gi]),
      .o_event     (w_lane_event[2*gi +: 2])
    );
  end

  assign spike_array = r_spike_array;
  assign event_array = r_event_array;
  assign frame_valid = r_frame_valid;

endmodule

// File: tb/tb_multichannel_spike_processor.sv
// Directed bench for multichannel_spike_processor (4 lanes, 16-bit samples).
module tb_multichannel_spike_processor;

  localparam int unsigned NumCh = 4;
  localparam int unsigned Dw    = 16;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic signed [Dw-1:0]   sample_in;
  logic                   sample_valid_in;
  logic                   frame_sync;
  logic [2*Dw-1:0]        threshold_in;
  logic                   threshold_we;
  logic [NumCh-1:0]       channel_enable;
  logic [NumCh-1:0]       spike_array;
  logic [2*NumCh-1:0]     event_array;
  logic                   frame_valid;

  multichannel_spike_processor #(
    .NUM_CHANNELS      (NumCh),
    .DATA_WIDTH        (Dw),
    .THRESHOLD_DEFAULT (32'd10000),
    .REFRACTORY        (8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sample_in       (sample_in),
    .sample_valid_in (sample_valid_in),
    .frame_sync      (frame_sync),
    .threshold_in    (threshold_in),
    .threshold_we    (threshold_we),
    .channel_enable  (channel_enable),
    .spike_array     (spike_array),
    .event_array     (event_array),
    .frame_valid     (frame_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int m_ptr    = 0;

  int               exp_fv_q[$];
  logic [NumCh-1:0] got_spike_q[$], exp_spike_q[$];
  logic [7:0]       got_event_q[$], exp_event_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every frame_valid pulse must match a predicted time (lane-3 accept edge + 2).
  always @(negedge clk) begin
    if (frame_valid) begin
      got_spike_q.push_back(spike_array);
      got_event_q.push_back(event_array);
      if (exp_fv_q.size() == 0) check_eq("fv_unexpected", frame_valid, 1'b0);
      else check_eq("fv_time", cyc, exp_fv_q.pop_front());
    end
  end

  task automatic send(input logic signed [Dw-1:0] v, input logic sync, input logic [NumCh-1:0] en);
    int lane;
    lane            = sync ? 0 : m_ptr;
    sample_in       = v;
    frame_sync      = sync;
    channel_enable  = en;
    sample_valid_in = 1'b1;
    @(posedge clk);
    #1;
    sample_valid_in = 1'b0;
    frame_sync      = 1'b0;
    if (lane == NumCh - 1) exp_fv_q.push_back(cyc + 2);
    m_ptr = (lane == NumCh - 1) ? 0 : lane + 1;
  endtask

  task automatic send_frame(input logic signed [Dw-1:0] l1, input logic [NumCh-1:0] en);
    send(16'sd0, 1'b0, en);
    send(l1, 1'b0, en);
    send(16'sd0, 1'b0, en);
    send(16'sd0, 1'b0, en);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_fv_q.delete();
    got_spike_q.delete();
    got_event_q.delete();
    exp_spike_q.delete();
    exp_event_q.delete();
    m_ptr = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic write_thr(input logic [2*Dw-1:0] t);
    threshold_in = t;
    threshold_we = 1'b1;
    @(posedge clk);
    #1;
    threshold_we = 1'b0;
  endtask

  task automatic expect_frame(input logic [NumCh-1:0] s, input logic [7:0] e);
    exp_spike_q.push_back(s);
    exp_event_q.push_back(e);
  endtask

  task automatic check_frames(input string tag);
    check_eq({tag, "_nframes"}, got_spike_q.size(), exp_spike_q.size());
    for (int i = 0; i < got_spike_q.size() && i < exp_spike_q.size(); i++) begin
      check_eq($sformatf("%s_spike_f%0d", tag, i + 1), got_spike_q[i], exp_spike_q[i]);
      check_eq($sformatf("%s_event_f%0d", tag, i + 1), got_event_q[i], exp_event_q[i]);
    end
    got_spike_q.delete();
    got_event_q.delete();
    exp_spike_q.delete();
    exp_event_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [Dw-1:0] refr_seq [14];
    logic signed [Dw-1:0] en_seq [4];
    logic [2*Dw-1:0]      thr_tab [3];
    logic [NumCh-1:0]     thr_spk [3];
    logic [7:0]           thr_evt [3];

    rst_n           = 1'b0;
    sample_in       = '0;
    sample_valid_in = 1'b0;
    frame_sync      = 1'b0;
    threshold_in    = '0;
    threshold_we    = 1'b0;
    channel_enable  = '1;

    // Reset state and a full-rate ramp 0..15: four silent frames.
    do_reset();
    check_eq("rst_spike", spike_array, 4'b0);
    check_eq("rst_event", event_array, 8'h00);
    check_eq("rst_fv", frame_valid, 1'b0);
    for (int i = 0; i < 16; i++) send(Dw'(i), 1'b0, 4'hF);
    idle(4);
    for (int i = 0; i < 4; i++) expect_frame(4'b0000, 8'h00);
    check_frames("ramp");

    // Lane-1 spike then refractory: suppressed at own samples 6 and 12, spikes at 4 and 14.
    refr_seq = '{16'sd0, 16'sd0, 16'sd1000, 16'sd0, 16'sd1000, 16'sd0, 16'sd0,
                 16'sd0, 16'sd0, 16'sd0, 16'sd1000, 16'sd0, 16'sd1000, 16'sd0};
    do_reset();
    for (int f = 0; f < 14; f++) send_frame(refr_seq[f], 4'hF);
    idle(4);
    for (int f = 1; f <= 14; f++) begin
      if (f == 4 || f == 14) expect_frame(4'b0010, 8'h04);
      else if (f == 6 || f == 12) expect_frame(4'b0000, 8'h0C);
      else expect_frame(4'b0000, 8'h00);
    end
    check_frames("refr");

    // Negative centre sample gives code 10.
    do_reset();
    send_frame(16'sd0, 4'hF);
    send_frame(16'sd0, 4'hF);
    send_frame(-16'sd1000, 4'hF);
    send_frame(16'sd0, 4'hF);
    idle(4);
    for (int f = 0; f < 3; f++) expect_frame(4'b0000, 8'h00);
    expect_frame(4'b0010, 8'h08);
    check_frames("neg");

    // Lane 1 disabled: silent. Re-enabled with empty history: needs two fills first.
    en_seq = '{16'sd1000, 16'sd0, 16'sd1000, 16'sd0};
    do_reset();
    for (int f = 0; f < 4; f++) send_frame(refr_seq[f], 4'b1101);
    for (int f = 0; f < 4; f++) send_frame(en_seq[f], 4'hF);
    idle(4);
    for (int f = 0; f < 7; f++) expect_frame(4'b0000, 8'h00);
    expect_frame(4'b0010, 8'h04);
    check_frames("enable");

    // frame_sync on 3rd sample of frame 4: lane-1 spike discarded, sync sample spikes lane 0.
    do_reset();
    for (int f = 0; f < 3; f++) send_frame(refr_seq[f], 4'hF);
    send(16'sd1000, 1'b0, 4'hF);
    send(16'sd0, 1'b0, 4'hF);
    send(16'sd0, 1'b1, 4'hF);
    send(16'sd0, 1'b0, 4'hF);
    send(16'sd0, 1'b0, 4'hF);
    send(16'sd0, 1'b0, 4'hF);
    idle(4);
    for (int f = 0; f < 3; f++) expect_frame(4'b0000, 8'h00);
    expect_frame(4'b0001, 8'h01);
    check_frames("sync");

    // Threshold: psi is exactly 1,000,000; compare is strict.
    thr_tab = '{32'd2000000, 32'd1000000, 32'd999999};
    thr_spk = '{4'b0000, 4'b0000, 4'b0010};
    thr_evt = '{8'h00, 8'h00, 8'h04};
    for (int t = 0; t < 3; t++) begin
      do_reset();
      write_thr(thr_tab[t]);
      for (int f = 0; f < 4; f++) send_frame(refr_seq[f], 4'hF);
      idle(4);
      for (int f = 0; f < 3; f++) expect_frame(4'b0000, 8'h00);
      expect_frame(thr_spk[t], thr_evt[t]);
      check_frames($sformatf("thr%0d", t));
    end

    // Threshold write on the same edge the spiking sample is in stage 2: old value applies.
    do_reset();
    for (int f = 0; f < 3; f++) send_frame(refr_seq[f], 4'hF);
    send(16'sd0, 1'b0, 4'hF);
    send(16'sd0, 1'b0, 4'hF);
    threshold_in = 32'd2000000;
    threshold_we = 1'b1;
    send(16'sd0, 1'b0, 4'hF);
    threshold_we = 1'b0;
    send(16'sd0, 1'b0, 4'hF);
    idle(4);
    for (int f = 0; f < 3; f++) expect_frame(4'b0000, 8'h00);
    expect_frame(4'b0010, 8'h04);
    check_frames("thr_race");

    // Outputs hold, then reset right after a lane-3 accept: no pulse, outputs cleared.
    do_reset();
    for (int f = 0; f < 4; f++) send_frame(refr_seq[f], 4'hF);
    idle(6);
    check_eq("hold_spike", spike_array, 4'b0010);
    check_eq("hold_event", event_array, 8'h04);
    send(16'sd5, 1'b0, 4'hF);
    send(16'sd1000, 1'b0, 4'hF);
    send(16'sd5, 1'b0, 4'hF);
    send(16'sd5, 1'b0, 4'hF);
    do_reset();
    idle(4);
    check_eq("midrst_spike", spike_array, 4'b0);
    check_eq("midrst_event", event_array, 8'h00);
    check_eq("midrst_nframes", got_spike_q.size(), 0);
    send_frame(16'sd0, 4'hF);
    idle(4);
    expect_frame(4'b0000, 8'h00);
    check_frames("post_rst");
    check_eq("fv_missing", exp_fv_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
